// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead byte FIFO feeding the UART transmitter.
// Core side pushes bytes and the transmitter pops them with 'next'.
// Software can poll the fill level, almost-full and a sticky overflow flag.
// Optional macro UART_TX_FIFO_FLUSH_EN adds a flush_i input. A flush empties
// the queue and leaves the overflow flag unchanged.
module uart_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                     flush_i,
`endif
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     clr_err_i,
    output logic [7:0]               d_out,
    output logic                     rts,
    input  logic                     next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PONE_C  = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic          full_s;
    logic          rts_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          flush_s;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_s = flush_i;
`else
    assign flush_s = 1'b0;
`endif

    // Status derived from the registered count only, so it is glitch-free.
    always_comb begin
        full_s        = (count_r == DEPTH_C);
        rts_s         = (count_r != {CW{1'b0}});
        almost_full_o = (count_r >= AF_C);
    end

    // Decide this cycle's pop, accepted push and dropped push.
    // A push at full is still accepted when a pop frees a slot in the same cycle.
    // A flush discards the push without counting it as a drop.
    always_comb begin
        pop_s  = next && rts_s;
        push_s = 1'b0;
        drop_s = 1'b0;
        if (wr_en_i && !flush_s) begin
            if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Pointer, count and sticky overflow registers; reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                count_r  <= {CW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PONE_C;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PONE_C;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + ONE_C;
                    2'b01:   count_r <= count_r - ONE_C;
                    default: count_r <= count_r;
                endcase
            end
            // A new drop wins over a clear in the same cycle.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err_i) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Byte storage; contents are not reset, because the count qualifies them.
    always_ff @(posedge clk_i) begin
        if (reset_i && push_s) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end
    end

    // Show-ahead head byte, forced to zero while the queue is empty.
    always_comb begin
        if (rts_s) begin
            d_out = mem_r[rd_ptr_r];
        end else begin
            d_out = 8'h00;
        end
    end

    assign rts        = rts_s;
    assign full_o     = full_s;
    assign count_o    = count_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. It keeps a queue-based reference model of the
// FIFO and compares the DUT with it on every falling edge. Directed vectors
// also carry hand-computed literal expectations.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [7:0] wr_data_i = 8'h00;
    logic       clr_err_i = 1'b0;
    logic       next = 1'b0;
    logic       flush_i = 1'b0;
    logic       full_o;
    logic       almost_full_o;
    logic [4:0] count_o;
    logic       overflow_o;
    logic [7:0] d_out;
    logic       rts;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    bit         chk_en = 1'b0;

    // Bytes actually handed to the transmitter, captured from the DUT.
    logic [7:0] dut_log[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(DEPTH - 2)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush_i      (flush_i),
`endif
        .wr_en_i      (wr_en_i),
        .wr_data_i    (wr_data_i),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .clr_err_i    (clr_err_i),
        .d_out        (d_out),
        .rts          (rts),
        .next         (next)
    );

    always #5 clk = ~clk;

    // Reference model: queue semantics applied at each rising edge.
    always @(posedge clk) begin
        bit was_full;
        bit do_pop;
        bit drop;
        logic [7:0] tmp;
        drop = 1'b0;
        if (!reset_i) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
`ifdef UART_TX_FIFO_FLUSH_EN
            if (flush_i) begin
                m_q.delete();
            end else
`endif
            begin
                was_full = (m_q.size() == DEPTH);
                do_pop   = next && (m_q.size() != 0);
                if (do_pop) tmp = m_q.pop_front();
                if (wr_en_i) begin
                    if (!was_full || do_pop) m_q.push_back(wr_data_i);
                    else drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_err_i) m_ovf = 1'b0;
        end
    end

    // Compare process: the DUT must match the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] exp_d;
            int n;
            n = m_q.size();
            exp_d = (n != 0) ? m_q[0] : 8'h00;
            checks++;
            if (count_o != 5'(n) || rts != (n != 0) || d_out != exp_d ||
                full_o != (n == DEPTH) || almost_full_o != (n >= DEPTH - 2) ||
                overflow_o != m_ovf || count_o > 5'd16) begin
                errors++;
                $display("FAIL model_cmp t=%0t got cnt=%0d rts=%0b d=%02h full=%0b af=%0b ovf=%0b exp cnt=%0d d=%02h ovf=%0b",
                         $time, count_o, rts, d_out, full_o, almost_full_o, overflow_o, n, exp_d, m_ovf);
            end
        end
    end

    // Applies one cycle of inputs, then returns at the following falling edge.
    task automatic step(input logic we, input logic [7:0] d, input logic nx,
                        input logic clr, input logic rst, input logic fl);
        wr_en_i = we; wr_data_i = d; next = nx; clr_err_i = clr;
        reset_i = rst; flush_i = fl;
        if (nx && rts && rst && !fl) dut_log.push_back(d_out);
        @(posedge clk);
        @(negedge clk);
        wr_en_i = 1'b0; next = 1'b0; clr_err_i = 1'b0; reset_i = 1'b1; flush_i = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    initial begin
        int gap;
        // Reset, then idle.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_rts", 32'(rts), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_dout", 32'(d_out), 32'h00);

        // Single byte.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("single_rts", 32'(rts), 32'd1);
        chk("single_dout", 32'(d_out), 32'hA5);
        chk("single_count", 32'(count_o), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("single_pop_rts", 32'(rts), 32'd0);
        chk("single_pop_count", 32'(count_o), 32'd0);
        chk("single_latched", 32'(dut_log[dut_log.size()-1]), 32'hA5);

        // Fill, then overflow.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 12) chk("af_at_13", 32'(almost_full_o), 32'd0);
            if (i == 13) chk("af_at_14", 32'(almost_full_o), 32'd1);
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_count", 32'(count_o), 32'd16);
        chk("fill_ovf", 32'(overflow_o), 32'd1);
        dut_log.delete();
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("drain_len", 32'(dut_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk("drain_byte", 32'(dut_log[i]), 32'(i));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_ovf", 32'(overflow_o), 32'd0);

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        dut_log.delete();
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pp_full_count", 32'(count_o), 32'd16);
        chk("pp_full_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pp_first", 32'(dut_log[0]), 32'h10);
        chk("pp_last", 32'(dut_log[16]), 32'h55);

        // Wrap-around with random idle gaps; one push overlaps each pop.
        dut_log.delete();
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b1, 8'((i * 7) % 256), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrap_len", 32'(dut_log.size()), 32'd40);
        for (int i = 0; i < 40; i++) chk("wrap_byte", 32'(dut_log[i]), 32'((i * 7) % 256));

        // Reset while 5 bytes are queued and next is asserted.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_rts", 32'(rts), 32'd0);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("midrst_next", 32'(dut_log[dut_log.size()-1]), 32'h3C);

`ifdef UART_TX_FIFO_FLUSH_EN
        // Flush with overflow set; the push in the flush cycle is discarded.
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fl_pre_ovf", 32'(overflow_o), 32'd1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("fl_count", 32'(count_o), 32'd0);
        chk("fl_rts", 32'(rts), 32'd0);
        chk("fl_ovf_kept", 32'(overflow_o), 32'd1);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fl_next", 32'(dut_log[dut_log.size()-1]), 32'h3C);
`endif

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO that sits directly upstream of the UART transmitter and buffers bytes written by the core's store path (memory-mapped TX data register). It presents a show-ahead head byte plus ready-to-send to the transmitter and pops on the transmitter's next-word request. It also reports fill level, almost-full and a sticky overflow flag for software polling.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
AF_LEVEL, DEPTH-2, count at or above which almost_full_o asserts; range 1..DEPTH

Ports:
clk_i  in  1  system clock, all logic on rising edge
reset_i  in  1  synchronous reset, active-low (0 = reset)
wr_en_i  in  1  push request from the core-side TX data register write
wr_data_i  in  8  byte to push
full_o  out  1  count == DEPTH
almost_full_o  out  1  count >= AF_LEVEL
count_o  out  $clog2(DEPTH)+1  current number of stored bytes
overflow_o  out  1  sticky: a push was dropped
clr_err_i  in  1  clears overflow_o
d_out  out  8  head byte to the UART transmitter data input
rts  out  1  ready-to-send to the transmitter: FIFO non-empty
next  in  1  pop request from the transmitter; transmitter latches d_out in the same cycle

Behaviour:
- Storage: DEPTH x 8 register array; read and write pointers of $clog2(DEPTH) bits wrap modulo DEPTH; separate count register of $clog2(DEPTH)+1 bits.
- Reset (reset_i == 0 at a rising edge): pointers = 0, count_o = 0, overflow_o = 0. Then rts = 0, full_o = 0, almost_full_o = 0, d_out = 8'h00. Array contents are not reset. Reset mid-stream discards all queued bytes, and reset overrides every other input that cycle.
- Show-ahead: d_out = mem[rd_ptr] combinationally whenever rts = 1. d_out is forced to 8'h00 when empty. rts = (count_o != 0), combinational from registered count.
- Push: accepted when wr_en_i && (!full_o || pop_this_cycle). The byte is written at wr_ptr and wr_ptr increments.
- Pop: pop_this_cycle = next && rts. rd_ptr increments. next while rts = 0 is ignored with no state change. The transmitter never asserts next without rts, so this case is defensive only.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- Full with simultaneous push and pop: both are accepted, count stays DEPTH, and no overflow.
- Full with push and no pop: the byte is dropped, pointers and count are unchanged, and overflow_o is set at the next edge.
- Empty with push: the byte appears on d_out and rts rises one cycle after the write edge. There is no fall-through in the same cycle. Minimum push-to-transmitter latency is 1 cycle.
- Overflow: sticky until clr_err_i = 1. If clr_err_i and a new drop occur in the same cycle, set wins and overflow_o stays 1.
- full_o, almost_full_o and count_o all derive from the registered count, so they are glitch-free and valid the cycle after the causing edge.
- Pointer wrap: after DEPTH pushes and pops, pointers return to 0 with no gap or duplication.

Optional Feature:
UART_TX_FIFO_FLUSH_EN
- Defined: adds input port flush_i (1 bit). flush_i = 1 at an edge resets pointers and count to 0, so rts drops the next cycle; overflow_o is kept. Flush has priority over push and pop in the same cycle, and that cycle's push is discarded without setting overflow. Transmission already latched by the transmitter is unaffected.
- Not defined: no flush_i port; the FIFO empties only by popping or by reset.

Test Plan:
- Reset then idle, DEPTH=16: hold reset_i=0 for 2 cycles, then release -> rts=0, count_o=0, full_o=0, overflow_o=0, d_out=8'h00.
- Single byte: push 8'hA5 in cycle N, no next -> cycle N+1 rts=1, d_out=8'hA5, count_o=1; pulse next -> following cycle rts=0, count_o=0.
- Fill and overflow: push 8'h00..8'h0F (16 bytes), then push 8'hFF -> full_o=1, almost_full_o=1 from count 14, count_o=16, overflow_o=1. Pop all 16 -> d_out sequence 8'h00..8'h0F, 8'hFF never seen. Pulse clr_err_i -> overflow_o=0.
- Push+pop at full: with count_o=16, assert wr_en_i=1 (8'h55) and next=1 in one cycle -> count_o stays 16, overflow_o=0, 8'h55 emerges last after 15 more pops.
- Wrap-around: 40 push/pop pairs with random gaps and bytes i*7 mod 256 -> output order exactly matches input, and count_o never exceeds 16 or underflows.
- Reset mid-operation: 5 bytes queued, reset_i=0 for one cycle while next=1 -> count_o=0, rts=0 next cycle; a subsequent push 8'h3C is the next byte out. With the flush macro defined, repeat using flush_i in place of reset -> same result, and overflow_o keeps its prior value.
